// File: rtl/puf_eval_ctrl_if.sv
// Request/response bundle between a PUF evaluation client and puf_eval_ctrl.
// The master side issues requests and presents the PUF responses; the slave is the controller.
interface puf_eval_ctrl_if #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 128,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int COUNT_WIDTH      = 8
) ();
    logic                        start;
    logic [CHALLENGE_WIDTH-1:0]  challenge_in;
    logic [PDL_CONFIG_WIDTH-1:0] pdl_config_in;
    logic [COUNT_WIDTH-1:0]      num_evals;
    logic                        busy;
    logic                        done;
    logic                        puf_trigger;
    logic                        puf_reset;
    logic [CHALLENGE_WIDTH-1:0]  puf_challenge;
    logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config;
    logic [RESPONSE_WIDTH-1:0]   puf_raw_response;
    logic                        puf_xor_response;
    logic [RESPONSE_WIDTH-1:0]   voted_response;
    logic                        voted_xor;
    logic [COUNT_WIDTH-1:0]      xor_ones;

    modport master (
        output start, challenge_in, pdl_config_in, num_evals,
        output puf_raw_response, puf_xor_response,
        input  busy, done, puf_trigger, puf_reset, puf_challenge, puf_pdl_config,
        input  voted_response, voted_xor, xor_ones
    );

    modport slave (
        input  start, challenge_in, pdl_config_in, num_evals,
        input  puf_raw_response, puf_xor_response,
        output busy, done, puf_trigger, puf_reset, puf_challenge, puf_pdl_config,
        output voted_response, voted_xor, xor_ones
    );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Repeated-evaluation PUF controller: arms, fires and samples the PUF N times,
// then reports a per-bit majority vote of the synchronized responses.
module puf_eval_ctrl #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 128,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int SETTLE_CYCLES    = 15,
    parameter int COUNT_WIDTH      = 8
) (
    input  logic          clk,
    input  logic          reset,
    puf_eval_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t                      state_reg, state_next;
    logic [7:0]                  settle_reg;
    logic [COUNT_WIDTH-1:0]      eval_reg;
    logic [COUNT_WIDTH-1:0]      eval_inc;
    logic [COUNT_WIDTH-1:0]      n_reg;
    logic [COUNT_WIDTH-1:0]      xor_cnt_reg;
    logic [COUNT_WIDTH-1:0]      xor_cnt_next;
    logic                        voted_xor_reg;
    logic [CHALLENGE_WIDTH-1:0]  challenge_reg;
    logic [PDL_CONFIG_WIDTH-1:0] pdl_config_reg;
    logic [RESPONSE_WIDTH-1:0]   raw_sync1_reg, raw_sync2_reg;
    logic                        xor_sync1_reg, xor_sync2_reg;
    logic [RESPONSE_WIDTH-1:0]   voted_bits;
    logic                        accept;
    logic                        sample_last;
    logic                        busy, done, puf_trigger, puf_reset;

    assign accept       = (state_reg == IDLE) && bus.start;
    assign eval_inc     = eval_reg + 1'b1;
    assign sample_last  = (state_reg == SAMPLE) && (eval_inc == n_reg);
    assign xor_cnt_next = xor_cnt_reg + COUNT_WIDTH'(xor_sync2_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = ARM;
            ARM:     state_next = FIRE;
            FIRE:    if (settle_reg == SETTLE_LAST) state_next = SAMPLE;
            SAMPLE:  state_next = (eval_inc == n_reg) ? DONE : ARM;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs: trigger and reset come straight from state, so an
    // asynchronous reset of the state register drops them at once.
    always_comb begin
        busy        = (state_reg != IDLE);
        done        = (state_reg == DONE);
        puf_trigger = (state_reg == FIRE);
        puf_reset   = (state_reg == ARM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_sync1_reg <= '0;
            raw_sync2_reg <= '0;
            xor_sync1_reg <= 1'b0;
            xor_sync2_reg <= 1'b0;
        end else begin
            raw_sync1_reg <= bus.puf_raw_response;
            raw_sync2_reg <= raw_sync1_reg;
            xor_sync1_reg <= bus.puf_xor_response;
            xor_sync2_reg <= xor_sync1_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_reg     <= '0;
            eval_reg       <= '0;
            n_reg          <= '0;
            xor_cnt_reg    <= '0;
            voted_xor_reg  <= 1'b0;
            challenge_reg  <= '0;
            pdl_config_reg <= '0;
        end else if (accept) begin
            settle_reg     <= '0;
            eval_reg       <= '0;
            n_reg          <= (bus.num_evals == '0) ? COUNT_WIDTH'(1) : bus.num_evals;
            xor_cnt_reg    <= '0;
            voted_xor_reg  <= 1'b0;
            challenge_reg  <= bus.challenge_in;
            pdl_config_reg <= bus.pdl_config_in;
        end else begin
            case (state_reg)
                ARM:  settle_reg <= '0;
                FIRE: settle_reg <= settle_reg + 1'b1;
                SAMPLE: begin
                    eval_reg    <= eval_inc;
                    xor_cnt_reg <= xor_cnt_next;
                    if (sample_last) begin
                        voted_xor_reg <= {xor_cnt_next, 1'b0} > {1'b0, n_reg};
                    end
                end
                default: ;
            endcase
        end
    end

    // One vote counter per raw response bit; the vote is taken with the
    // final sample folded in, so the result is ready in the DONE cycle.
    generate
        for (genvar gi = 0; gi < RESPONSE_WIDTH; gi++) begin : g_vote
            logic [COUNT_WIDTH-1:0] cnt_reg;
            logic [COUNT_WIDTH-1:0] cnt_next;
            logic                   vote_reg;

            assign cnt_next       = cnt_reg + COUNT_WIDTH'(raw_sync2_reg[gi]);
            assign voted_bits[gi] = vote_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    vote_reg <= 1'b0;
                end else if (accept) begin
                    cnt_reg  <= '0;
                    vote_reg <= 1'b0;
                end else if (state_reg == SAMPLE) begin
                    cnt_reg <= cnt_next;
                    if (sample_last) begin
                        vote_reg <= {cnt_next, 1'b0} > {1'b0, n_reg};
                    end
                end
            end
        end
    endgenerate

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.puf_trigger    = puf_trigger;
    assign bus.puf_reset      = puf_reset;
    assign bus.puf_challenge  = challenge_reg;
    assign bus.puf_pdl_config = pdl_config_reg;
    assign bus.voted_response = voted_bits;
    assign bus.voted_xor      = voted_xor_reg;
    assign bus.xor_ones       = xor_cnt_reg;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: expected votes and latency are queued at
// start and checked when done pulses.
module tb_puf_eval_ctrl;
    localparam int CW = 64;
    localparam int PW = 128;
    localparam int RW = 6;
    localparam int SC = 15;
    localparam int NW = 8;

    typedef struct {
        logic [RW-1:0] vr;
        logic          vx;
        logic [NW-1:0] xo;
        int            lat;
        logic [CW-1:0] ch;
        logic [PW-1:0] cfg;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [RW-1:0] raw_tab [8];
    logic          xor_tab [8];

    puf_eval_ctrl_if #(.CHALLENGE_WIDTH(CW), .PDL_CONFIG_WIDTH(PW),
                       .RESPONSE_WIDTH(RW), .COUNT_WIDTH(NW)) bus ();

    puf_eval_ctrl #(
        .CHALLENGE_WIDTH(CW), .PDL_CONFIG_WIDTH(PW), .RESPONSE_WIDTH(RW),
        .SETTLE_CYCLES(SC), .COUNT_WIDTH(NW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.puf_trigger !== 1'b0 ||
            bus.puf_reset !== 1'b0 || bus.voted_response !== '0 || bus.voted_xor !== 1'b0 ||
            bus.xor_ones !== '0 || bus.puf_challenge !== '0 || bus.puf_pdl_config !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b trig=%b prst=%b vr=%b vx=%b xo=%0d ch=%h required all 0",
                     tag, bus.busy, bus.done, bus.puf_trigger, bus.puf_reset,
                     bus.voted_response, bus.voted_xor, bus.xor_ones, bus.puf_challenge);
        end
    endtask

    // Runs one request, feeding raw_tab/xor_tab[k] to evaluation k when ARM is seen.
    task automatic run_op(input logic [NW-1:0] n, input logic [CW-1:0] ch,
                          input logic [PW-1:0] cfg, input bit inject, input string tag);
        int   ne, xo, dones, ev, c0;
        bit   overlap;
        exp_t e, got;
        ne = (n == 0) ? 1 : int'(n);
        xo = 0;
        e.vr = '0;
        for (int b = 0; b < RW; b++) begin
            int c;
            c = 0;
            for (int k = 0; k < ne; k++) c += int'(raw_tab[k][b]);
            e.vr[b] = (2 * c > ne);
        end
        for (int k = 0; k < ne; k++) xo += int'(xor_tab[k]);
        e.xo  = NW'(xo);
        e.vx  = (2 * xo > ne);
        e.lat = ne * (SC + 2) + 1;
        e.ch  = ch;
        e.cfg = cfg;
        sb.push_back(e);

        @(negedge clk);
        bus.start = 1'b1;
        bus.challenge_in = ch;
        bus.pdl_config_in = cfg;
        bus.num_evals = n;
        c0 = cyc;
        dones = 0;
        ev = 0;
        overlap = 1'b0;
        for (int rel = 1; rel <= e.lat + 6; rel++) begin
            @(negedge clk);
            if (inject && (rel == 5 || rel == 10)) begin
                bus.start = 1'b1;
                bus.challenge_in = ~ch;
                bus.pdl_config_in = ~cfg;
            end else begin
                bus.start = 1'b0;
            end
            if (rel == 1) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.puf_reset !== 1'b1 || bus.xor_ones !== '0 ||
                    bus.voted_response !== '0 || bus.voted_xor !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_arm_clear: busy=%b prst=%b xo=%0d vr=%b vx=%b required busy=1 prst=1 cleared",
                             tag, bus.busy, bus.puf_reset, bus.xor_ones, bus.voted_response, bus.voted_xor);
                end
            end
            if (bus.puf_reset === 1'b1 && ev < ne) begin
                bus.puf_raw_response = raw_tab[ev];
                bus.puf_xor_response = xor_tab[ev];
                ev++;
            end
            if (bus.puf_reset === 1'b1 && bus.puf_trigger === 1'b1) overlap = 1'b1;
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 1 && sb.size() > 0) begin
                    got = sb.pop_front();
                    checks++;
                    if (rel != got.lat) begin
                        errors++;
                        $display("FAIL %s_latency: done at %0d required %0d", tag, rel, got.lat);
                    end
                    checks++;
                    if (bus.voted_response !== got.vr || bus.voted_xor !== got.vx ||
                        bus.xor_ones !== got.xo) begin
                        errors++;
                        $display("FAIL %s_result: vr=%b vx=%b xo=%0d required vr=%b vx=%b xo=%0d",
                                 tag, bus.voted_response, bus.voted_xor, bus.xor_ones, got.vr, got.vx, got.xo);
                    end
                    checks++;
                    if (bus.puf_challenge !== got.ch || bus.puf_pdl_config !== got.cfg) begin
                        errors++;
                        $display("FAIL %s_capture: ch=%h required %h", tag, bus.puf_challenge, got.ch);
                    end
                    $display("op %s: n=%0d done at +%0d vr=%b vx=%b xo=%0d", tag, n, rel,
                             bus.voted_response, bus.voted_xor, bus.xor_ones);
                end
            end
            if (rel == e.lat + 3) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.voted_response !== e.vr || bus.voted_xor !== e.vx ||
                    bus.xor_ones !== e.xo) begin
                    errors++;
                    $display("FAIL %s_hold: busy=%b vr=%b vx=%b xo=%0d required busy=0 vr=%b vx=%b xo=%0d",
                             tag, bus.busy, bus.voted_response, bus.voted_xor, bus.xor_ones, e.vr, e.vx, e.xo);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s_done_count: saw %0d done pulses required 1 (start cycle %0d)", tag, dones, c0);
            if (dones == 0 && sb.size() > 0) void'(sb.pop_front());
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL %s_trig_reset_overlap: overlap=1 required 0", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_state");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_release");
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        raw_tab[0] = 6'b101101;
        xor_tab[0] = 1'b0;
        run_op(8'd1, 64'h0123_4567_89ab_cdef, {4{32'hdead_beef}}, 1'b0, "single");
    endtask

    task automatic test_majority();
        raw_tab[0] = 6'b000011; xor_tab[0] = 1'b1;
        raw_tab[1] = 6'b000001; xor_tab[1] = 1'b1;
        raw_tab[2] = 6'b000010; xor_tab[2] = 1'b0;
        run_op(8'd3, 64'hfeed_0000_1111_2222, {4{32'h1234_5678}}, 1'b0, "majority");
    endtask

    task automatic test_tie();
        raw_tab[0] = 6'b111000; xor_tab[0] = 1'b1;
        raw_tab[1] = 6'b111111; xor_tab[1] = 1'b0;
        run_op(8'd2, 64'h5555_aaaa_5555_aaaa, {4{32'h0f0f_0f0f}}, 1'b0, "tie");
    endtask

    task automatic test_n_zero();
        raw_tab[0] = 6'b010110;
        xor_tab[0] = 1'b1;
        run_op(8'd0, 64'h0000_0000_0000_0042, {4{32'hcafe_f00d}}, 1'b0, "n_zero");
    endtask

    task automatic test_start_ignored();
        raw_tab[0] = 6'b110011;
        xor_tab[0] = 1'b1;
        run_op(8'd1, 64'h1357_9bdf_2468_ace0, {4{32'h8421_1248}}, 1'b1, "start_ignored");
    endtask

    task automatic test_reset_mid();
        int  stray;
        raw_tab[0] = 6'b100001;
        xor_tab[0] = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.challenge_in = 64'habcd_abcd_abcd_abcd;
        bus.num_evals = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int rel = 2; rel <= 9; rel++) @(negedge clk);
        checks++;
        if (bus.puf_trigger !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fire: trig=%b required 1", bus.puf_trigger);
        end
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid_async");
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) stray++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_mid_stray: %0d cycles with done/busy required 0", stray);
        end
        $display("reset_mid: trigger dropped, no done");
        raw_tab[0] = 6'b011110;
        xor_tab[0] = 1'b0;
        run_op(8'd1, 64'h7777_8888_9999_0000, {4{32'h3c3c_3c3c}}, 1'b0, "after_reset");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.challenge_in = '0;
        bus.pdl_config_in = '0;
        bus.num_evals = '0;
        bus.puf_raw_response = '0;
        bus.puf_xor_response = 1'b0;
        test_reset();
        test_single();
        test_majority();
        test_tie();
        test_n_zero();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameter CHALLENGE_WIDTH, default 64, challenge bus width.
REQ-002 Parameter PDL_CONFIG_WIDTH, default 128, PDL configuration bus width.
REQ-003 Parameter RESPONSE_WIDTH, default 6, raw PUF response width.
REQ-004 Parameter SETTLE_CYCLES, default 15, trigger-high cycles per evaluation, legal range 1 to 255.
REQ-005 Parameter COUNT_WIDTH, default 8, width of the evaluation count and vote counters.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 start  in  1  request strobe, sampled only in IDLE.
REQ-010 challenge_in  in  CHALLENGE_WIDTH  challenge, captured on an accepted start.
REQ-011 pdl_config_in  in  PDL_CONFIG_WIDTH  PDL configuration, captured on an accepted start.
REQ-012 num_evals  in  COUNT_WIDTH  evaluation count N, captured on an accepted start; 0 is treated as 1.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse, high when the result is valid.
REQ-015 puf_trigger  out  1  drives the PUF interconnect trigger.
REQ-016 puf_reset  out  1  drives the PUF interconnect reset.
REQ-017 puf_challenge  out  CHALLENGE_WIDTH  registered copy of the captured challenge.
REQ-018 puf_pdl_config  out  PDL_CONFIG_WIDTH  registered copy of the captured PDL configuration.
REQ-019 puf_raw_response  in  RESPONSE_WIDTH  raw PUF response, asynchronous to clk.
REQ-020 puf_xor_response  in  1  XOR-compressed PUF response, asynchronous to clk.
REQ-021 voted_response  out  RESPONSE_WIDTH  per-bit majority of raw responses.
REQ-022 voted_xor  out  1  majority of XOR responses.
REQ-023 xor_ones  out  COUNT_WIDTH  number of evaluations that returned xor=1.

Function
REQ-024 Both response inputs SHALL pass through a two-flop synchronizer; all sampling SHALL use the synchronizer outputs.
REQ-025 The FSM SHALL have the states IDLE, ARM, FIRE, SAMPLE and DONE.
REQ-026 IDLE: when start=1, the block SHALL capture the challenge, configuration and N, clear all vote counters and the evaluation counter, and go to ARM.
REQ-027 ARM: puf_reset=1 and puf_trigger=0 for exactly one cycle, then go to FIRE.
REQ-028 FIRE: puf_trigger=1 for exactly SETTLE_CYCLES consecutive cycles, then go to SAMPLE.
REQ-029 SAMPLE, one cycle, trigger low: add each synced raw bit to its counter; add synced xor to xor_ones; increment the evaluation counter.
REQ-030 SAMPLE exit: if the evaluation counter equals N, go to DONE; otherwise go to ARM.
REQ-031 DONE, one cycle: done=1; voted_response[i]=1 iff 2*count_i > N (a tie gives 0); voted_xor uses the same rule; then go to IDLE.
REQ-032 Latency: start accepted at cycle t gives done high at cycle t + N*(SETTLE_CYCLES+2) + 1.
REQ-033 The voted outputs and xor_ones SHALL hold their values from DONE until the next accepted start, which clears them to 0.
REQ-034 puf_challenge and puf_pdl_config SHALL remain constant from capture until the next accepted start.
REQ-035 start while busy=1 SHALL be ignored, with no queuing.
REQ-036 Counters SHALL compute the 2*count comparison at COUNT_WIDTH+1 bits, so no overflow is possible; a count never exceeds N.
REQ-037 puf_trigger and puf_reset SHALL never be high in the same cycle.

Reset
REQ-038 On reset: state=IDLE; busy, done, puf_trigger, puf_reset, voted_response, voted_xor, xor_ones, all counters, the synchronizers, puf_challenge and puf_pdl_config SHALL all be 0.
REQ-039 Reset asserted mid-operation SHALL drop puf_trigger within the same cycle (asynchronously) with no done pulse; the first start after reset release SHALL run a full sequence.

Verification
REQ-040 Single evaluation: N=1, SETTLE=15, response held at 6'b101101 with xor=0, start at cycle 0 -> ARM at cycle 1, trigger high cycles 2-16, done at cycle 18, voted_response=101101, xor_ones=0.
REQ-041 Majority: N=3, raw responses 000011, 000001, 000010 across the three evaluations -> voted_response=000011, done at cycle 52.
REQ-042 Tie: N=2, xor responses 1 then 0 -> xor_ones=1, voted_xor=0.
REQ-043 N=0 -> exactly one evaluation, identical to N=1 timing.
REQ-044 start pulsed at cycles 5 and 10 during a run -> only one done pulse; the captured challenge is unchanged.
REQ-045 reset asserted at cycle 8 of a FIRE phase -> trigger low immediately and all outputs 0; a start after release gives a normal done at t+18.
